// File: rtl/sum_block_acc_pkg.sv
// Shared types and sizing helper for the block accumulator.
package sum_block_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width needed to count 0..block_len inclusive.
    function automatic int cnt_w(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/sum_block_accumulator.sv
// Accumulates {cout,sum} beats into a block total; optional max tracker under SUM_BLOCK_ACC_PEAK_EN.
// Latency: summary valid 1 cycle after the BLOCK_LEN-th accept; next block accepts 1 cycle after handshake.
// Backpressure: in_ready drops while a summary waits; out_* hold stable until out_ready.
module sum_block_accumulator
    import sum_block_acc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_sum,
    input  logic                         in_cout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_total,
    output logic [cnt_w(BLOCK_LEN)-1:0]  out_carries,
    output logic                         out_ovf
`ifdef SUM_BLOCK_ACC_PEAK_EN
    ,
    output logic [DATA_W:0]              out_peak
`endif
);

    localparam int              CNT_W = cnt_w(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    if (ACC_W < DATA_W + 1) begin : g_acc_w_check
        $error("ACC_W must be at least DATA_W+1");
    end
    if (BLOCK_LEN < 1) begin : g_block_len_check
        $error("BLOCK_LEN must be at least 1");
    end

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   total;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   carries;
    logic               ovf;
    logic               accept;
    logic               done;
    logic [ACC_W:0]     sum_ext;

    assign accept  = in_valid & in_ready;
    assign done    = out_valid & out_ready;
    // Extra top bit captures the wrap out of the running total.
    assign sum_ext = {1'b0, total} + {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            case (state)
                ACCUM: begin
                    in_ready = 1'b1;
                    if (in_valid && count == LAST) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_nxt = ACCUM;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            total   <= '0;
            count   <= '0;
            carries <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            total   <= sum_ext[ACC_W-1:0];
            count   <= count + CNT_W'(1);
            carries <= carries + CNT_W'(in_cout);
            ovf     <= ovf | sum_ext[ACC_W];
        end
    end

    assign out_total   = total;
    assign out_carries = carries;
    assign out_ovf     = ovf;

`ifdef SUM_BLOCK_ACC_PEAK_EN
    logic [DATA_W:0] peak;

    always_ff @(posedge clk) begin
        if (rst || done) begin
            peak <= '0;
        end else if (accept && {in_cout, in_sum} > peak) begin
            peak <= {in_cout, in_sum};
        end
    end

    assign out_peak = peak;
`endif

endmodule
